// File: rtl/uart_tx_wb.sv
// Wishbone pipelined slave with a TX FIFO feeding an 8N1 UART serializer.
// Registers: TXDATA, STATUS, DIV; the fourth slot is reserved and errors.
module uart_tx_wb #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_err_o,
    output logic        txd_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        txd_d;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [4:0]  count_q;
    logic        empty, full, busy;
    logic        acc, push, pop, err_c;
    logic [1:0]  addr;
    logic [15:0] div_w;
    logic [31:0] rdata;
    logic        unused;

    assign unused = ^{wb_adr_i[31:4], wb_adr_i[1:0],
                      wb_dat_i[31:16], wb_sel_i[3:2]};

    assign wb_stall_o = 1'b0;
    assign acc   = wb_cyc_i & wb_stb_i;
    assign addr  = wb_adr_i[3:2];
    assign empty = (count_q == 5'd0);
    assign full  = (count_q == 5'(FIFO_DEPTH));
    assign busy  = (state_q != IDLE);

    // Full is judged on the registered count; a same-cycle pop frees nothing.
    assign push  = acc & wb_we_i & (addr == 2'd0) & wb_sel_i[0] & ~full;
    assign err_c = acc & ((addr == 2'd3) |
                   (wb_we_i & (addr == 2'd0) & wb_sel_i[0] & full));

    assign div_w = {wb_sel_i[1] ? wb_dat_i[15:8] : div_q[15:8],
                    wb_sel_i[0] ? wb_dat_i[7:0]  : div_q[7:0]};

    always_comb begin
        rdata = 32'd0;
        if (!wb_we_i) begin
            unique case (addr)
                2'd1:    rdata = {19'd0, count_q, 5'd0, busy, full, empty};
                2'd2:    rdata = {16'd0, div_q};
                default: rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'd0;
            div_q    <= 16'(CLK_DIV);
        end else begin
            wb_ack_o <= acc & ~err_c;
            wb_err_o <= err_c;
            wb_dat_o <= (acc & ~err_c) ? rdata : 32'd0;
            if (acc & wb_we_i & (addr == 2'd2) & (|wb_sel_i[1:0]))
                div_q <= (div_w < 16'd2) ? 16'd2 : div_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_q] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= 5'd0;
        end else begin
            if (push)
                wr_q <= wr_q + AW'(1);
            if (pop)
                rd_q <= rd_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = mem[rd_q];
                    cnt_d   = div_q - 16'd1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = div_q - 16'd1;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = div_q - 16'd1;
                    sh_d  = sh_q >> 1;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                    else
                        bit_d = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    // Chain straight into the next start bit when more is queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = mem[rd_q];
                        cnt_d   = div_q - 16'd1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = sh_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            txd_o   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_o   <= txd_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_wb.sv
// Bench for uart_tx_wb: bus transfers plus a line receiver that decodes
// frames independently and compares against queued bytes.
module tb_uart_tx_wb;
    localparam int CLK_DIV = 868;
    localparam logic [31:0] A_TX  = 32'h2020;
    localparam logic [31:0] A_ST  = 32'h2024;
    localparam logic [31:0] A_DIV = 32'h2028;
    localparam logic [31:0] A_RSV = 32'h202C;

    logic        clk = 0;
    logic        reset_i = 0;
    logic        cyc = 0, stb = 0, we = 0;
    logic [31:0] adr = 0, dat = 0;
    logic [3:0]  sel = 0;
    logic        stall, ack, err, txd;
    logic [31:0] rdat;

    int n_chk = 0;
    int n_bad = 0;
    int cur_div = CLK_DIV;
    longint cycle = 0;
    logic [7:0] rx_q [$];
    longint     rx_t [$];

    uart_tx_wb #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(8)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_stall_o(stall), .wb_ack_o(ack), .wb_dat_o(rdat),
        .wb_err_o(err), .txd_o(txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Line receiver: samples each bit near its middle at the current divisor.
    logic [9:0] m_bits;
    logic       m_abort;
    longint     m_t0;
    int         m_d;
    always begin
        @(negedge clk);
        if (reset_i && txd === 1'b0) begin
            m_t0 = cycle;
            m_d = cur_div;
            m_abort = 0;
            m_bits = '0;
            for (int k = 0; k <= m_d / 2 + 9 * m_d; k++) begin
                if (k > 0) @(negedge clk);
                if (!reset_i) m_abort = 1;
                if (k >= m_d / 2 && (k - m_d / 2) % m_d == 0)
                    m_bits[(k - m_d / 2) / m_d] = txd;
            end
            if (!m_abort) begin
                n_chk++;
                if (m_bits[0] !== 1'b0 || m_bits[9] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL framing: bits=%b required start 0 stop 1",
                             m_bits);
                end
                rx_q.push_back(m_bits[8:1]);
                rx_t.push_back(m_t0);
            end
        end
    end

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic o_ack, output logic o_err,
                        output logic [31:0] o_dat);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
        @(negedge clk);
        o_ack = ack; o_err = err; o_dat = rdat;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic set_div(input int d);
        logic a, e;
        logic [31:0] r;
        xfer(1, A_DIV, d, 4'b0011, a, e, r);
        cur_div = d;
    endtask

    task automatic test_reset;
        logic a, e;
        logic [31:0] r;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({ack, err, rdat, stall, txd} !== {2'b0, 32'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_outs: ack=%b err=%b dat=%h stall=%b txd=%b",
                     ack, err, rdat, stall, txd);
        end
        reset_i = 1;
        xfer(0, A_ST, 0, 4'hF, a, e, r);
        n_chk++;
        if (a !== 1'b1 || r !== 32'h1) begin
            n_bad++;
            $display("FAIL reset_status: ack=%b got %h want 00000001", a, r);
        end
        xfer(0, A_DIV, 0, 4'hF, a, e, r);
        n_chk++;
        if (r !== 32'(CLK_DIV)) begin
            n_bad++;
            $display("FAIL reset_div: got %0d want %0d", r, CLK_DIV);
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        logic a, e;
        logic [31:0] r;
        logic [9:0] fr;
        logic want;
        set_div(4);
        rx_q.delete(); rx_t.delete();
        fr = {1'b1, b, 1'b0};
        xfer(1, A_TX, {24'd0, b}, 4'hF, a, e, r);
        n_chk++;
        if (a !== 1'b1 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL single_ack: ack=%b err=%b want 1 0", a, e);
        end
        for (int j = 0; j <= 41; j++) begin
            @(negedge clk);
            want = (j == 0 || j == 41) ? 1'b1 : fr[(j - 1) / 4];
            n_chk++;
            if (txd !== want) begin
                n_bad++;
                $display("FAIL single_wave[%0d]: txd=%b want %b", j, txd, want);
            end
        end
        xfer(0, A_ST, 0, 4'hF, a, e, r);
        n_chk++;
        if (r !== 32'h1) begin
            n_bad++;
            $display("FAIL single_status: got %h want 00000001", r);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] b [10];
        logic a_v [10], e_v [10];
        logic a, e;
        logic [31:0] r;
        set_div(100);
        rx_q.delete(); rx_t.delete();
        for (int k = 0; k < 10; k++) b[k] = 8'($urandom);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k > 0) begin a_v[k-1] = ack; e_v[k-1] = err; end
            if (k < 10) begin
                cyc = 1; stb = 1; we = 1; adr = A_TX;
                dat = {24'd0, b[k]}; sel = 4'h1;
            end else begin
                cyc = 0; stb = 0; we = 0;
            end
        end
        for (int k = 0; k < 10; k++) begin
            n_chk++;
            if (a_v[k] !== (k < 9) || e_v[k] !== (k == 9)) begin
                n_bad++;
                $display("FAIL ovf_resp[%0d]: ack=%b err=%b", k, a_v[k], e_v[k]);
            end
        end
        xfer(0, A_ST, 0, 4'hF, a, e, r);
        n_chk++;
        if (r !== 32'h0000_0806) begin
            n_bad++;
            $display("FAIL ovf_status: got %h want 00000806", r);
        end
        repeat (9 * 1000 + 100) @(negedge clk);
        n_chk++;
        if (rx_q.size() != 9) begin
            n_bad++;
            $display("FAIL ovf_count: got %0d frames want 9", rx_q.size());
        end
        for (int k = 0; k < 9 && k < rx_q.size(); k++) begin
            n_chk++;
            if (rx_q[k] !== b[k]) begin
                n_bad++;
                $display("FAIL ovf_byte[%0d]: got %h want %h", k, rx_q[k], b[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b [2];
        set_div(3);
        rx_q.delete(); rx_t.delete();
        b[0] = 8'h55; b[1] = 8'h0F;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            if (k < 2) begin
                cyc = 1; stb = 1; we = 1; adr = A_TX;
                dat = {24'd0, b[k]}; sel = 4'hF;
            end else begin
                cyc = 0; stb = 0; we = 0;
            end
        end
        repeat (80) @(negedge clk);
        n_chk++;
        if (rx_q.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 2", rx_q.size());
        end else begin
            n_chk++;
            if (rx_q[0] !== b[0] || rx_q[1] !== b[1]) begin
                n_bad++;
                $display("FAIL b2b_bytes: got %h %h want 55 0f",
                         rx_q[0], rx_q[1]);
            end
            n_chk++;
            if (rx_t[1] - rx_t[0] != 30) begin
                n_bad++;
                $display("FAIL b2b_gap: got %0d cycles want 30",
                         rx_t[1] - rx_t[0]);
            end
        end
    endtask

    task automatic test_edges;
        logic a, e;
        logic [31:0] r;
        xfer(0, A_RSV, 0, 4'hF, a, e, r);
        n_chk++;
        if (a !== 1'b0 || e !== 1'b1) begin
            n_bad++;
            $display("FAIL rsv_read: ack=%b err=%b want 0 1", a, e);
        end
        xfer(1, A_RSV, 32'hFF, 4'hF, a, e, r);
        n_chk++;
        if (a !== 1'b0 || e !== 1'b1) begin
            n_bad++;
            $display("FAIL rsv_write: ack=%b err=%b want 0 1", a, e);
        end
        xfer(1, A_TX, 32'h77, 4'b1110, a, e, r);
        n_chk++;
        if (a !== 1'b1 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL sel_nopush_ack: ack=%b err=%b want 1 0", a, e);
        end
        xfer(1, A_ST, 32'hFFFF, 4'hF, a, e, r);
        xfer(0, A_ST, 0, 4'hF, a, e, r);
        n_chk++;
        if (r !== 32'h1) begin
            n_bad++;
            $display("FAIL sel_nopush_status: got %h want 00000001", r);
        end
        xfer(1, A_DIV, 32'h1, 4'b0011, a, e, r);
        xfer(0, A_DIV, 0, 4'hF, a, e, r);
        n_chk++;
        if (r !== 32'd2) begin
            n_bad++;
            $display("FAIL div_clamp: got %0d want 2", r);
        end
        xfer(1, A_DIV, 32'h0000_1234, 4'b0010, a, e, r);
        xfer(0, A_DIV, 0, 4'hF, a, e, r);
        n_chk++;
        if (r !== 32'h1202) begin
            n_bad++;
            $display("FAIL div_lane: got %h want 00001202", r);
        end
        cur_div = 32'h1202;
    endtask

    task automatic test_random;
        logic a, e;
        logic [31:0] r;
        logic [7:0] exp_q [$];
        int n, d;
        d = $urandom_range(2, 6);
        n = $urandom_range(1, 8);
        set_div(d);
        rx_q.delete(); rx_t.delete();
        for (int k = 0; k < n; k++) begin
            logic [7:0] v;
            v = 8'($urandom);
            exp_q.push_back(v);
            xfer(1, A_TX, {24'($urandom), v}, 4'h1, a, e, r);
            n_chk++;
            if (a !== 1'b1 || e !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_ack[%0d]: ack=%b err=%b", k, a, e);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (n * 10 * d + 60) @(negedge clk);
        n_chk++;
        if (rx_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL rnd_count: got %0d want %0d", rx_q.size(), n);
        end
        for (int k = 0; k < n && k < rx_q.size(); k++) begin
            n_chk++;
            if (rx_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL rnd_byte[%0d]: got %h want %h",
                         k, rx_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic a, e;
        logic [31:0] r;
        logic [7:0] b;
        set_div(8);
        b = 8'($urandom) & 8'hFD;
        xfer(1, A_TX, {24'd0, b}, 4'h1, a, e, r);
        repeat (22) @(negedge clk);
        n_chk++;
        if (txd !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_pre: txd=%b want 0", txd);
        end
        #2 reset_i = 0;
        #1;
        n_chk++;
        if (txd !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_async: txd=%b want 1", txd);
        end
        cur_div = CLK_DIV;
        repeat (3) @(negedge clk);
        reset_i = 1;
        rx_q.delete(); rx_t.delete();
        repeat (200) @(negedge clk);
        n_chk++;
        if (rx_q.size() != 0) begin
            n_bad++;
            $display("FAIL mid_notx: got %0d frames want 0", rx_q.size());
        end
        xfer(0, A_ST, 0, 4'hF, a, e, r);
        n_chk++;
        if (r !== 32'h1) begin
            n_bad++;
            $display("FAIL mid_status: got %h want 00000001", r);
        end
    endtask

    initial begin
        test_reset;
        test_single(8'hA5);
        test_single(8'($urandom));
        test_overflow;
        test_back_to_back;
        test_edges;
        test_random;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
